// File: rtl/mult_div_hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: datapath width,
// iteration count and the sequencing state encoding.
package mult_div_hilo_pkg;

   localparam int MD_DATA_WIDTH = 32;
   localparam int MD_ITER_COUNT = MD_DATA_WIDTH;
   localparam int MD_CNT_WIDTH  = $clog2(MD_ITER_COUNT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } md_state_e;

endpackage

// File: rtl/div_magnitude_core.sv
// Unsigned restoring divider on operand magnitudes, one quotient bit per cycle.
// Also owns the iteration counter shared with the multiply sequence.
module div_magnitude_core
   import mult_div_hilo_pkg::*;
#(
   parameter int W  = MD_DATA_WIDTH,
   parameter int CW = $clog2(W)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         count_en,
   input  logic         div_en,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         last,
   output logic [W-1:0] quot_nxt,
   output logic [W-1:0] rem_nxt
);

   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

   logic [CW-1:0] cnt_r;
   logic [W-1:0]  quot_r;
   logic [W-1:0]  rem_r;
   logic [W-1:0]  dvsr_r;
   logic [W:0]    shifted_s;
   logic [W:0]    trial_s;

   // Trial subtraction; a borrow in the top bit means restore the shifted remainder.
   always_comb begin
      shifted_s = {rem_r, quot_r[W-1]};
      trial_s   = shifted_s - {1'b0, dvsr_r};
      if (trial_s[W]) begin
         quot_nxt = {quot_r[W-2:0], 1'b0};
         rem_nxt  = shifted_s[W-1:0];
      end else begin
         quot_nxt = {quot_r[W-2:0], 1'b1};
         rem_nxt  = trial_s[W-1:0];
      end
   end

   assign last = (cnt_r == CNT_LAST);

   // Counter and divider working registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r  <= {CW{1'b0}};
         quot_r <= {W{1'b0}};
         rem_r  <= {W{1'b0}};
         dvsr_r <= {W{1'b0}};
      end else if (load) begin
         cnt_r  <= {CW{1'b0}};
         quot_r <= dividend;
         rem_r  <= {W{1'b0}};
         dvsr_r <= divisor;
      end else begin
         if (count_en) begin
            cnt_r <= cnt_r + CNT_ONE;
         end
         if (div_en) begin
            quot_r <= quot_nxt;
            rem_r  <= rem_nxt;
         end
      end
   end

endmodule

// File: rtl/mult_div_hilo.sv
// Sequential signed multiply (Booth radix-2) / divide (restoring) unit owning HI/LO.
// HI/LO change only on entry to DONE or on reset.
module mult_div_hilo
   import mult_div_hilo_pkg::*;
#(
   parameter int DATA_WIDTH = MD_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_mult,
   input  logic                  start_div,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH-1:0] hi,
   output logic [DATA_WIDTH-1:0] lo,
   output logic                  busy,
   output logic                  done,
   output logic                  div_zero
);

   localparam int W = DATA_WIDTH;
   localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
   localparam logic [W-1:0] ZERO = {W{1'b0}};

   function automatic logic [W-1:0] cond_neg(input logic [W-1:0] v, input logic neg);
      cond_neg = neg ? (~v + ONE) : v;
   endfunction

   md_state_e state_r, state_nxt_s;
   logic         start_m_s, start_d_s, dz_s;
   logic [W-1:0] acc_r, q_r, m_r;
   logic         q1_r;
   logic         q_sign_r, r_sign_r;
   logic [W-1:0] hi_r, lo_r;
   logic         busy_r, done_r, div_zero_r;
   logic [W:0]   booth_sum_s;
   logic [W-1:0] booth_acc_nxt_s, booth_q_nxt_s;
   logic         last_s;
   logic [W-1:0] quot_nxt_s, rem_nxt_s;

   // Next-state decode with start arbitration; multiply wins over divide.
   always_comb begin
      state_nxt_s = state_r;
      start_m_s   = 1'b0;
      start_d_s   = 1'b0;
      dz_s        = 1'b0;
      case (state_r)
         IDLE: begin
            if (start_mult) begin
               state_nxt_s = MULT;
               start_m_s   = 1'b1;
            end else if (start_div) begin
               if (b == ZERO) begin
                  state_nxt_s = DONE;
                  dz_s        = 1'b1;
               end else begin
                  state_nxt_s = DIV;
                  start_d_s   = 1'b1;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         MULT:    state_nxt_s = last_s ? DONE : MULT;
         DIV:     state_nxt_s = last_s ? DONE : DIV;
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Booth step; the add is one bit wider so the most negative multiplicand cannot overflow the shift.
   always_comb begin
      case ({q_r[0], q1_r})
         2'b01:   booth_sum_s = {acc_r[W-1], acc_r} + {m_r[W-1], m_r};
         2'b10:   booth_sum_s = {acc_r[W-1], acc_r} - {m_r[W-1], m_r};
         default: booth_sum_s = {acc_r[W-1], acc_r};
      endcase
      booth_acc_nxt_s = booth_sum_s[W:1];
      booth_q_nxt_s   = {booth_sum_s[0], q_r[W-1:1]};
   end

   div_magnitude_core #(.W(W)) u_div (
      .clk      (clk),
      .reset    (reset),
      .load     (start_m_s | start_d_s),
      .count_en ((state_r == MULT) || (state_r == DIV)),
      .div_en   (state_r == DIV),
      .dividend (cond_neg(a, a[W-1])),
      .divisor  (cond_neg(b, b[W-1])),
      .last     (last_s),
      .quot_nxt (quot_nxt_s),
      .rem_nxt  (rem_nxt_s)
   );

   // State, Booth working register, sign capture and HI/LO write on entry to DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= IDLE;
         acc_r      <= ZERO;
         q_r        <= ZERO;
         m_r        <= ZERO;
         q1_r       <= 1'b0;
         q_sign_r   <= 1'b0;
         r_sign_r   <= 1'b0;
         hi_r       <= ZERO;
         lo_r       <= ZERO;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         div_zero_r <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         busy_r     <= (state_nxt_s != IDLE);
         done_r     <= (state_nxt_s == DONE);
         div_zero_r <= dz_s;
         if (start_m_s) begin
            acc_r <= ZERO;
            q_r   <= b;
            q1_r  <= 1'b0;
            m_r   <= a;
         end else if (state_r == MULT) begin
            acc_r <= booth_acc_nxt_s;
            q_r   <= booth_q_nxt_s;
            q1_r  <= q_r[0];
         end
         if (start_d_s) begin
            q_sign_r <= a[W-1] ^ b[W-1];
            r_sign_r <= a[W-1];
         end
         if ((state_r == MULT) && last_s) begin
            hi_r <= booth_acc_nxt_s;
            lo_r <= booth_q_nxt_s;
         end else if ((state_r == DIV) && last_s) begin
            hi_r <= cond_neg(rem_nxt_s, r_sign_r);
            lo_r <= cond_neg(quot_nxt_s, q_sign_r);
         end
      end
   end

   assign hi       = hi_r;
   assign lo       = lo_r;
   assign busy     = busy_r;
   assign done     = done_r;
   assign div_zero = div_zero_r;

endmodule

// File: tb/tb_mult_div_hilo.sv
// Directed bench for mult_div_hilo: table of multiply/divide vectors plus
// hand-written sequences for arbitration, ignored starts and mid-operation reset.
module tb_mult_div_hilo;

   logic        clk;
   logic        reset;
   logic        start_mult;
   logic        start_div;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;
   logic        div_zero;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      string       name;
      logic        is_div;
      logic [31:0] av;
      logic [31:0] bv;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      logic        exp_dz;
      int          exp_lat;
   } vec_t;

   vec_t vecs[11];

   mult_div_hilo #(.DATA_WIDTH(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .start_mult (start_mult),
      .start_div  (start_div),
      .a          (a),
      .b          (b),
      .hi         (hi),
      .lo         (lo),
      .busy       (busy),
      .done       (done),
      .div_zero   (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Start in cycle 0, return at the negedge of the done cycle (or after the cycle budget).
   task automatic do_op(input logic sm, input logic sd, input logic [31:0] av, input logic [31:0] bv,
                        output int lat, output logic dz, output logic bz);
      @(negedge clk);
      start_mult = sm;
      start_div  = sd;
      a          = av;
      b          = bv;
      @(negedge clk);
      start_mult = 1'b0;
      start_div  = 1'b0;
      a          = $urandom;
      b          = $urandom;
      lat        = 1;
      bz         = 1'b1;
      while (done !== 1'b1 && lat < 40) begin
         if (busy !== 1'b1) bz = 1'b0;
         @(negedge clk);
         lat++;
      end
      if (busy !== 1'b1) bz = 1'b0;
      dz = div_zero;
   endtask

   initial begin
      int   lat;
      logic dz;
      logic bz;
      int   ndone;
      int   dcyc;

      vecs[0]  = '{"mul_7x-3",      1'b0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33};
      vecs[1]  = '{"mul_min_x_min", 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33};
      vecs[2]  = '{"mul_m1_x_m1",   1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 33};
      vecs[3]  = '{"mul_x16",       1'b0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 33};
      vecs[4]  = '{"div_-7_2",      1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
      vecs[5]  = '{"div_7_-2",      1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33};
      vecs[6]  = '{"div_min_-1",    1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
      vecs[7]  = '{"div_100_7",     1'b1, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0, 33};
      vecs[8]  = '{"div_min_min",   1'b1, 32'h80000000, 32'h80000000, 32'h00000000, 32'h00000001, 1'b0, 33};
      vecs[9]  = '{"mul_preload",   1'b0, 32'h33333333, 32'h55555556, 32'h11111111, 32'h22222222, 1'b0, 33};
      vecs[10] = '{"div_by_zero",   1'b1, 32'h00000005, 32'h00000000, 32'h11111111, 32'h22222222, 1'b1, 1};

      reset      = 1'b1;
      start_mult = 1'b0;
      start_div  = 1'b0;
      a          = 32'h0;
      b          = 32'h0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_hi", hi, 32'h0);
      check("rst_lo", lo, 32'h0);
      check("rst_flags", {29'h0, busy, done, div_zero}, 32'h0);

      // Back-to-back: each start lands in cycle 34 of the previous operation.
      for (int i = 0; i < 11; i++) begin
         do_op(~vecs[i].is_div, vecs[i].is_div, vecs[i].av, vecs[i].bv, lat, dz, bz);
         check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
         check({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
         check({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
         check({vecs[i].name, "_dz"}, {31'h0, dz}, {31'h0, vecs[i].exp_dz});
         check({vecs[i].name, "_busy"}, {31'h0, bz}, 32'h1);
      end

      // Both starts together: multiply wins.
      do_op(1'b1, 1'b1, 32'h00000006, 32'h00000007, lat, dz, bz);
      check("both_lat", 32'(lat), 32'd33);
      check("both_hi", hi, 32'h0);
      check("both_lo", lo, 32'd42);
      check("both_dz", {31'h0, dz}, 32'h0);
      @(negedge clk);
      check("after_done_flags", {30'h0, busy, done}, 32'h0);

      // start_div with b=0 during a multiply must be ignored.
      @(negedge clk);
      start_mult = 1'b1;
      a          = 32'd3;
      b          = 32'd5;
      ndone      = 0;
      dcyc       = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         start_mult = 1'b0;
         start_div  = (c == 10);
         if (c == 10) b = 32'h0;
         if (done === 1'b1) begin
            ndone++;
            dcyc = c;
         end
      end
      start_div = 1'b0;
      check("ign_ndone", 32'(ndone), 32'd1);
      check("ign_dcyc", 32'(dcyc), 32'd33);
      check("ign_hi", hi, 32'h0);
      check("ign_lo", lo, 32'd15);

      // Reset in cycle 15 of a multiply aborts it.
      @(negedge clk);
      start_mult = 1'b1;
      a          = 32'd9;
      b          = 32'd9;
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         start_mult = 1'b0;
         if (c == 15) reset = 1'b1;
      end
      @(negedge clk);
      reset = 1'b0;
      check("midrst_hi", hi, 32'h0);
      check("midrst_lo", lo, 32'h0);
      check("midrst_flags", {29'h0, busy, done, div_zero}, 32'h0);
      ndone = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      check("midrst_no_done", 32'(ndone), 32'd0);
      check("midrst_lo_hold", lo, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mult_div_hilo.md
# mult_div_hilo

Sequential signed multiply/divide unit that owns the HI and LO registers of the multicycle datapath. It runs a radix-2 Booth multiply or a restoring divide over 32 iterations and writes the result into HI/LO. Its `hi` and `lo` outputs feed the register write-data selection stage directly downstream, for mfhi/mflo write-back. Control starts an operation with a one-cycle strobe, then waits on `busy`/`done`.

## Interface
- `DATA_WIDTH`, default 32: operand width and HI/LO width. The iteration count equals `DATA_WIDTH`. Only 32 is verified.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `start_mult`  in  1: start a signed multiply of `a`×`b`. Sampled only in IDLE.
- `start_div`  in  1: start a signed divide `a`÷`b`. Sampled only in IDLE.
- `a`  in  32: multiplicand/dividend. Captured on the start edge.
- `b`  in  32: multiplier/divisor. Captured on the start edge.
- `hi`  out  32: HI register. Upper product half, or remainder.
- `lo`  out  32: LO register. Lower product half, or quotient.
- `busy`  out  1: high whenever state ≠ IDLE.
- `done`  out  1: one-cycle pulse in the DONE state.
- `div_zero`  out  1: one-cycle pulse coincident with `done` when a divide had `b`=0.

## Operation
- **States:** IDLE, MULT, DIV, DONE.
- **IDLE → MULT** on `start_mult`.
- **IDLE → DIV** on `start_div` with `b`≠0.
- **IDLE → DONE** on `start_div` with `b`=0.
- **MULT/DIV → DONE** after 32 iterations; the counter runs 0..31.
- **DONE → IDLE** unconditionally.
- **Start arbitration:**
  - If both starts are high in IDLE, multiply wins and `start_div` is dropped.
  - Starts outside IDLE are ignored, not queued.
- **Multiply:** Booth radix-2 on the signed 65-bit {A, Q, Q₋₁} register, with one arithmetic shift per cycle. On entry to DONE: `hi`=product[63:32], `lo`=product[31:0].
- **Divide:**
  - Restoring divide on operand magnitudes, one quotient bit per cycle.
  - Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a), i.e. truncation toward zero.
  - On entry to DONE: `lo`=quotient, `hi`=remainder.
  - −2³¹ ÷ −1 yields `lo`=0x80000000, `hi`=0. No trap.
- **Divide by zero:** `hi`/`lo` hold their previous values; `div_zero`=1 together with `done`.
- **Holding:** `hi`/`lo` change only on entry to DONE or on reset, and otherwise hold indefinitely. Working registers are internal and never visible on `hi`/`lo`.

## Timing
- **Reset values:** `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_zero`=0, state=IDLE, counter=0.
- **Reset mid-operation:** aborts and clears per the reset values; no `done` pulse.
- **Normal operation (start high in cycle 0):**
  - `busy`=1 in cycles 1..33.
  - Iterations run in cycles 1..32.
  - `hi`/`lo` are updated at the edge ending cycle 32 and are valid from cycle 33.
  - `done`=1 in cycle 33.
  - The next start is accepted when sampled at the end of cycle 34 (i.e. start high in cycle 34).
- **Divide by zero:** `busy`=1 and `done`=`div_zero`=1 in cycle 1 only.
- **Inputs:** `a`/`b` may change freely after the start edge.

## Structure
- **Shared package:** state enum (IDLE/MULT/DIV/DONE), `DATA_WIDTH`, and the iteration-count constant. Control-unit FSMs reference these for wait-state sizing.
- **Sub-module:** `div_magnitude_core` is a natural split, holding the unsigned restoring-divide datapath, counter and remainder register. Booth, the FSM, sign fix-up and HI/LO stay in the top.

## Test plan
- **Multiply, negative result:** 7 × −3 (`b`=0xFFFFFFFD) → `done` in cycle 33, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB, `busy` high in cycles 1..33.
- **Multiply, extreme operands:** 0x80000000 × 0x80000000 → `hi`=0x40000000, `lo`=0x00000000. Then 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0, `lo`=1.
- **Divide, sign handling:**
  - −7 ÷ 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - 7 ÷ −2 → `lo`=0xFFFFFFFD, `hi`=1.
  - −2³¹ ÷ −1 → `lo`=0x80000000, `hi`=0.
- **Divide by zero:** preload HI/LO with 0x11111111/0x22222222 via a prior multiply, then 5 ÷ 0 → `done`=`div_zero`=1 in cycle 1, HI/LO unchanged.
- **Start arbitration:**
  - Both starts high in IDLE → multiply result.
  - `start_div` pulsed in cycle 10 of a multiply → ignored, with exactly one `done`.
  - Reset asserted in cycle 15 → all outputs 0 next cycle, no `done`.
